// File: rtl/i_buf_ds_seq_pkg.sv
// Shared types and helpers for the differential input buffer enable sequencer.
package i_buf_ds_seq_pkg;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ENABLE = 2'd1,
      ST_SETTLE = 2'd2,
      ST_READY  = 2'd3
   } seq_state_t;

   // Width of the shared gap/settle down-counter: wide enough for the larger interval
   function automatic int cnt_width(input int gap, input int settle);
      int mx;
      mx = (gap > settle) ? gap : settle;
      if (mx < 1) mx = 1;
      return $clog2(mx + 1);
   endfunction

endpackage

// File: rtl/i_buf_ds_en_seq_lane_next_sel.sv
// Priority encoder: finds the lowest set mask bit at or above a search index
// and flags whether it is the final set bit of the mask.
module lane_next_sel
   import i_buf_ds_seq_pkg::*;
#(
   parameter int NUM_LANES = 4,
   parameter int LW        = 3
) (
   input  logic [NUM_LANES-1:0] i_mask,
   input  logic [LW-1:0]        i_from,
   output logic [LW-1:0]        o_next,
   output logic [NUM_LANES-1:0] o_next_oh,
   output logic                 o_found,
   output logic                 o_last
);

   logic w_more;

   // Scan upward from i_from; the first hit is the next lane, any later hit means more remain
   always_comb begin
      o_next    = '0;
      o_next_oh = '0;
      o_found   = 1'b0;
      w_more    = 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (i_mask[i] && (LW'(i) >= i_from)) begin
            if (!o_found) begin
               o_found      = 1'b1;
               o_next       = LW'(i);
               o_next_oh[i] = 1'b1;
            end else begin
               w_more = 1'b1;
            end
         end
      end
      o_last = o_found & ~w_more;
   end

endmodule

// File: rtl/i_buf_ds_en_seq.sv
// Staggered enable sequencer: raises selected buffer enables one lane per gap,
// waits a settle interval, then reports the group ready until stopped.
module i_buf_ds_en_seq
   import i_buf_ds_seq_pkg::*;
#(
   parameter int NUM_LANES     = 4,
   parameter int GAP_CYCLES    = 4,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   input  logic                 STOP,
   input  logic [NUM_LANES-1:0] LANE_MASK,
   output logic [NUM_LANES-1:0] EN,
   output logic                 BUSY,
   output logic                 READY,
   output logic                 ERR
);

   // Lane index must be able to hold NUM_LANES itself (search start past the top lane)
   localparam int LW = $clog2(NUM_LANES + 1);
   localparam int CW = cnt_width(GAP_CYCLES, SETTLE_CYCLES);

   // Counters load interval-1 so the event lands exactly interval edges later
   localparam logic [CW-1:0] GAP_LD    = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);

   seq_state_t           r_state;
   logic [NUM_LANES-1:0] r_mask;
   logic [LW-1:0]        r_lane;
   logic [CW-1:0]        r_cnt;
   logic [NUM_LANES-1:0] r_en;
   logic                 r_busy;
   logic                 r_ready;
   logic                 r_err;

   logic [NUM_LANES-1:0] w_sel_mask;
   logic [LW-1:0]        w_from;
   logic [LW-1:0]        w_next;
   logic [NUM_LANES-1:0] w_next_oh;
   logic                 w_found;
   logic                 w_last;

   // In IDLE search the live mask from lane 0; otherwise search the captured mask above the current lane
   always_comb begin
      w_sel_mask = r_mask;
      w_from     = r_lane + LW'(1);
      if (r_state == ST_IDLE) begin
         w_sel_mask = LANE_MASK;
         w_from     = '0;
      end
   end

   lane_next_sel #(
      .NUM_LANES (NUM_LANES),
      .LW        (LW)
   ) u_next (
      .i_mask    (w_sel_mask),
      .i_from    (w_from),
      .o_next    (w_next),
      .o_next_oh (w_next_oh),
      .o_found   (w_found),
      .o_last    (w_last)
   );

   // Sequencer state, counter and registered outputs
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= ST_IDLE;
         r_mask  <= '0;
         r_lane  <= '0;
         r_cnt   <= '0;
         r_en    <= '0;
         r_busy  <= 1'b0;
         r_ready <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_err <= 1'b0;
         if (STOP && (r_state != ST_IDLE)) begin
            // Abort clears every enable at once
            r_state <= ST_IDLE;
            r_mask  <= '0;
            r_lane  <= '0;
            r_cnt   <= '0;
            r_en    <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (START && !STOP) begin
                     if (w_found) begin
                        r_mask <= LANE_MASK;
                        r_lane <= w_next;
                        r_en   <= r_en | w_next_oh;
                        r_busy <= 1'b1;
                        if (w_last) begin
                           r_state <= ST_SETTLE;
                           r_cnt   <= SETTLE_LD;
                        end else begin
                           r_state <= ST_ENABLE;
                           r_cnt   <= GAP_LD;
                        end
                     end else begin
                        r_err <= 1'b1;
                     end
                  end
               end
               ST_ENABLE: begin
                  if (r_cnt == '0) begin
                     if (w_found) begin
                        r_lane <= w_next;
                        r_en   <= r_en | w_next_oh;
                     end
                     if (w_last || !w_found) begin
                        r_state <= ST_SETTLE;
                        r_cnt   <= SETTLE_LD;
                     end else begin
                        r_cnt <= GAP_LD;
                     end
                  end else begin
                     r_cnt <= r_cnt - CW'(1);
                  end
               end
               ST_SETTLE: begin
                  if (r_cnt == '0) begin
                     r_state <= ST_READY;
                     r_busy  <= 1'b0;
                     r_ready <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt - CW'(1);
                  end
               end
               default: begin
                  r_state <= r_state;
               end
            endcase
         end
      end
   end

   assign EN    = r_en;
   assign BUSY  = r_busy;
   assign READY = r_ready;
   assign ERR   = r_err;

endmodule

// File: doc/i_buf_ds_en_seq.md
# i_buf_ds_en_seq

Staggered enable sequencer for a group of differential input buffers. On a start request it raises each selected buffer's `EN` one lane at a time, spaced by a programmable gap so that receiver bias currents come up gradually. It then waits a settle interval before reporting the group ready. It sits in fabric between the I/O bank configuration logic and the `EN` pins of up to `NUM_LANES` differential input buffers.

## Interface
- `NUM_LANES`, 4: number of buffer enables driven; legal range 1..32.
- `GAP_CYCLES`, 4: clock cycles between consecutive lane enables; must be ≥1.
- `SETTLE_CYCLES`, 16: clock cycles from the last lane enable to `READY`; must be ≥1.

Ports:
- `CLK` in 1: single clock; all state changes on the rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `START` in 1: sequence request; level-sampled on each rising edge.
- `STOP` in 1: abort/shutdown request; level-sampled on each rising edge.
- `LANE_MASK` in `NUM_LANES`: lanes to enable; captured when `START` is accepted.
- `EN` out `NUM_LANES`: registered enables to the buffers.
- `BUSY` out 1: high in ENABLE and SETTLE.
- `READY` out 1: high in READY state.
- `ERR` out 1: one-cycle pulse when `START` is rejected because the mask is zero.

## Operation
- States:
  - IDLE: no lanes enabled.
  - ENABLE: stepping through lanes.
  - SETTLE: waiting out the settle interval.
  - READY: all selected lanes enabled and settled.
- Reset (`RST`=0), asynchronous: state IDLE; `EN`=0, `BUSY`=0, `READY`=0, `ERR`=0; mask register and counter cleared.
- Transitions:
  - IDLE, `START`=1, `LANE_MASK`≠0: capture the mask, set `EN` bit of the lowest set lane, go to ENABLE.
  - IDLE, `START`=1, `LANE_MASK`=0: stay in IDLE, pulse `ERR` for one cycle.
  - ENABLE: after `GAP_CYCLES` cycles, set the next higher captured lane; lanes with mask bit 0 are skipped and cost no time.
  - ENABLE → SETTLE: in the same edge that sets the final lane.
  - SETTLE → READY: after `SETTLE_CYCLES` cycles.
  - READY: held until `STOP`.
- `STOP`=1 in any non-IDLE state: at the next edge `EN`=0, `BUSY`=0, `READY`=0, state IDLE.
- `STOP`=1 in IDLE: no effect.
- `START` and `STOP` high together: `STOP` wins. In IDLE nothing happens and `ERR` does not pulse.
- `START` outside IDLE is ignored. `LANE_MASK` changes after capture are ignored.
- `EN` bits only rise, one per step, until `STOP` or reset clears them all together.
- Counter width is `$clog2(max(GAP_CYCLES,SETTLE_CYCLES)+1)`. The counter saturates at 0 and never wraps.

## Timing
- Reference point: the accepting edge is t0. With m selected lanes:
  - `EN` of the k-th selected lane (k=0..m-1) rises at t0+k·`GAP_CYCLES`.
  - `BUSY` rises at t0.
  - `READY` rises and `BUSY` falls at t0+(m−1)·`GAP_CYCLES`+`SETTLE_CYCLES`.
- m=1: `EN` rises at t0 and `READY` rises at t0+`SETTLE_CYCLES`.
- `STOP` sampled at edge t: all outputs clear at t.
- `ERR` is high for exactly the one cycle after the rejecting edge.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `i_buf_ds_seq_pkg` holds:
  - the state enum (IDLE, ENABLE, SETTLE, READY);
  - the counter-width function.
- Sub-module `lane_next_sel`: a combinational priority encoder.
  - Inputs: captured mask and current lane index.
  - Outputs: next set lane above the index, plus a `last` flag.

## Test plan
- Reset: hold `RST`=0 with `START`=1 → `EN`=0, `BUSY`=0, `READY`=0, `ERR`=0 throughout. After release with `START`=0, all outputs stay at 0.
- Full mask, defaults, `START` accepted at edge 10 → `EN`[0]@10, `EN`[1]@14, `EN`[2]@18, `EN`[3]@22; `READY`=1 and `BUSY`=0 @38.
- `LANE_MASK`=4'b0101 accepted at t0 → `EN`[0]@t0, `EN`[2]@t0+4; `EN`[1] and `EN`[3] stay 0; `READY`@t0+20. Changing `LANE_MASK` after t0 has no effect.
- `STOP` sampled at t0+6 of a full-mask run → `EN`=0 and `BUSY`=0 at that edge. `START` at t0+6 in the same cycle is ignored. A new `START` two edges later restarts from lane 0.
- `START` with `LANE_MASK`=0 → `ERR` high for one cycle, state stays IDLE. `START` held during SETTLE → timing unchanged from the full-mask case.
- `RST` pulled low asynchronously mid-SETTLE → outputs 0 before the next `CLK` edge. After release, the block waits for a fresh `START`.
